// File: rtl/uart_rx_ext.sv
// UART receiver: 2-flop synchroniser, 2-of-3 mid-bit majority, optional parity (UART_RX_PARITY_EN).
// Latency: rx_valid rises 1 cycle after the majority decision of the last stop bit.
// Backpressure: word held until rx_valid & rx_ready; a frame completing while held is dropped with an overrun_err pulse.
module uart_rx_ext #(
   parameter int SYS_CLK_FRE = 50_000_000,
   parameter int BPS         = 115200,
   parameter int DATA_BITS   = 8,
   parameter int STOP_BITS   = 1,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 uart_rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err
);

   localparam int BPS_CNT = SYS_CLK_FRE / BPS;
   localparam logic [15:0] CNT_LAST  = 16'(BPS_CNT - 1);
   localparam logic [15:0] SMP_A     = 16'(BPS_CNT / 2 - 1);
   localparam logic [15:0] SMP_B     = 16'(BPS_CNT / 2);
   localparam logic [15:0] SMP_C     = 16'(BPS_CNT / 2 + 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       (PARITY_ODD != 0 && PARITY_ODD != 1) || BPS_CNT < 4) begin : g_cfg_bad
      $error("uart_rx_ext: unsupported parameter combination");
   end

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                state, state_nxt;
   logic                  rxd_s1, rxd_s2;
   logic [1:0]            rst_flush;
   logic                  armed;
   logic [15:0]           clk_cnt;
   logic [3:0]            bit_idx;
   logic [1:0]            smp;
   logic                  maj;
   logic                  at_dec, at_end;
   logic [DATA_BITS-1:0]  shreg;
   logic                  stop_bad;
   logic                  frame_done;
   logic                  frame_err_nxt;
`ifdef UART_RX_PARITY_EN
   logic                  par_bit;
   logic                  parity_err_q;
   logic                  parity_err_nxt;
`endif

   assign maj    = (smp[1] & smp[0]) | (smp[1] & rxd_s2) | (smp[0] & rxd_s2);
   assign at_dec = (clk_cnt == SMP_C);
   assign at_end = (clk_cnt == CNT_LAST);

   assign frame_err_nxt = stop_bad | ~maj;
`ifdef UART_RX_PARITY_EN
   assign parity_err_nxt = ((^shreg) ^ par_bit) != (PARITY_ODD != 0);
   assign parity_err     = parity_err_q;
`else
   assign parity_err     = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      case (state)
         IDLE:  if (armed && !rxd_s2) state_nxt = START;
         START: begin
            if (at_dec && maj) state_nxt = IDLE;
            else if (at_end)   state_nxt = DATA;
         end
         DATA: begin
            if (at_end && bit_idx == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (at_end) state_nxt = STOP;
`endif
         STOP: begin
            // leave on the last decision, not at the end of the stop bit
            if (at_dec && bit_idx == STOP_LAST) begin
               state_nxt  = IDLE;
               frame_done = 1'b1;
            end else if (at_end) begin
               state_nxt  = STOP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rxd_s1    <= 1'b1;
         rxd_s2    <= 1'b1;
         rst_flush <= 2'b00;
         armed     <= 1'b0;
         clk_cnt   <= 16'd0;
         bit_idx   <= 4'd0;
         smp       <= 2'b00;
         shreg     <= '0;
         stop_bad  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         rxd_s1    <= uart_rxd;
         rxd_s2    <= rxd_s1;
         rst_flush <= {rst_flush[0], 1'b1};
         if (state == IDLE) begin
            clk_cnt  <= 16'd0;
            bit_idx  <= 4'd0;
            stop_bad <= 1'b0;
            // only a genuinely observed high line arms the start detector (break / post-reset)
            if (state_nxt == START)            armed <= 1'b0;
            else if (rst_flush[1] && rxd_s2)   armed <= 1'b1;
         end else begin
            clk_cnt <= at_end ? 16'd0 : clk_cnt + 16'd1;
            if (clk_cnt == SMP_A) smp[0] <= rxd_s2;
            if (clk_cnt == SMP_B) smp[1] <= rxd_s2;
            if (at_dec) begin
               case (state)
                  DATA:    shreg <= {maj, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                  PARITY:  par_bit <= maj;
`endif
                  STOP:    if (!maj) stop_bad <= 1'b1;
                  default: ;
               endcase
            end
            if (at_end) bit_idx <= (state_nxt != state) ? 4'd0 : bit_idx + 4'd1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         overrun_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         overrun_err <= 1'b0;
         if (frame_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data      <= shreg;
               frame_err    <= frame_err_nxt;
               rx_valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
               parity_err_q <= parity_err_nxt;
`endif
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
